// File: rtl/intersection_scheduler_pkg.sv
// Shared types and constants for the intersection scheduler.
package intersection_scheduler_pkg;

  // Light head encoding, shared by both roads.
  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_GREEN  = 2'd1;
  localparam logic [1:0] LIGHT_YELLOW = 2'd2;

  // Scheduler phases; encoding 7 is unused and treated as illegal.
  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED2  = 3'd5,
    WALK  = 3'd6
  } state_e;

  localparam logic [2:0] STATE_ILLEGAL = 3'd7;

  // Default phase durations in clock cycles.
  localparam int DEF_GREEN_A  = 40;
  localparam int DEF_GREEN_B  = 20;
  localparam int DEF_YELLOW_T = 5;
  localparam int DEF_ALLRED_T = 2;
  localparam int DEF_WALK_T   = 15;

endpackage

// File: rtl/intersection_scheduler_timer.sv
// Shared phase timer: loadable 8-bit down-counter that stops at zero.
module phase_timer #(
  parameter logic [7:0] RESET_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       zero
);

  // Load wins over counting so a phase entry is never lost; counting freezes at 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (en && (count != 8'd0))
      count <= count - 8'd1;
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer with pedestrian walk phase and safety flags.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int GREEN_A  = DEF_GREEN_A,
  parameter int GREEN_B  = DEF_GREEN_B,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int WALK_T   = DEF_WALK_T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_b,
  input  logic       ped_req,
  input  logic       hold,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic       walk,
  output logic       ped_ack,
  output logic [7:0] time_left,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4,
  output logic       p5
);

  // Timer reload values are duration - 1 so a phase of T lasts exactly T cycles.
  localparam logic [7:0] GREEN_A_M1  = 8'(GREEN_A - 1);
  localparam logic [7:0] GREEN_B_M1  = 8'(GREEN_B - 1);
  localparam logic [7:0] YELLOW_T_M1 = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_T_M1 = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_T_M1   = 8'(WALK_T - 1);

  state_e     state_q;
  state_e     state_d;
  logic       illegal;
  logic       advance;
  logic       t_load;
  logic [7:0] t_load_val;
  logic       t_zero;
  logic       car_pend;
  logic       ped_pend;
  logic       enter_b_grn;
  logic       enter_walk;
  logic [7:0] cur_len_m1;

  // Reload value for a phase; the illegal encoding maps to the widest value.
  function automatic logic [7:0] phase_len_m1(input logic [2:0] s);
    case (s)
      A_GRN:         phase_len_m1 = GREEN_A_M1;
      A_YEL, B_YEL:  phase_len_m1 = YELLOW_T_M1;
      RED1, RED2:    phase_len_m1 = ALLRED_T_M1;
      B_GRN:         phase_len_m1 = GREEN_B_M1;
      WALK:          phase_len_m1 = WALK_T_M1;
      default:       phase_len_m1 = 8'hFF;
    endcase
  endfunction

  assign illegal = (3'(state_q) == STATE_ILLEGAL);

  phase_timer #(
    .RESET_VAL (GREEN_A_M1)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (!hold),
    .count    (time_left),
    .zero     (t_zero)
  );

  // State register; hold is folded into state_d so reset still dominates here.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= A_GRN;
    else
      state_q <= state_d;
  end

  // Next-state logic: phases only move on a zero timer and no hold; illegal recovers unconditionally.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    advance = 1'b0;
    if (illegal) begin
      state_d = A_GRN;
      advance = 1'b1;
    end else if (!hold && t_zero) begin
      advance = 1'b1;
      case (state_q)
        A_GRN: begin
          if (car_pend || ped_pend)
            state_d = A_YEL;
          else
            advance = 1'b0;
        end
        A_YEL:   state_d = RED1;
        RED1:    state_d = ped_pend ? WALK : B_GRN;
        B_GRN:   state_d = B_YEL;
        B_YEL:   state_d = RED2;
        RED2:    state_d = ped_pend ? WALK : A_GRN;
        WALK:    state_d = A_GRN;
        default: state_d = A_GRN;
      endcase
    end
    t_load     = advance;
    t_load_val = phase_len_m1(3'(state_d));
  end

  assign enter_b_grn = advance && (state_d == B_GRN);
  assign enter_walk  = advance && (state_d == WALK);

  // Request latches: always track inputs (even on hold); entry into the serving phase clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_pend <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      car_pend <= (car_pend || car_b) && !enter_b_grn;
      ped_pend <= (ped_pend || ped_req) && !enter_walk;
    end
  end

  // Walk acknowledge pulse, frozen while held so outputs stay stable.
  always_ff @(posedge clk) begin
    if (reset)
      ped_ack <= 1'b0;
    else if (!hold)
      ped_ack <= enter_walk;
  end

  // Output decode: lights, walk lamp and safety properties from the state register.
  always_comb begin
    light_a = LIGHT_RED;
    light_b = LIGHT_RED;
    walk    = 1'b0;
    case (state_q)
      A_GRN:   light_a = LIGHT_GREEN;
      A_YEL:   light_a = LIGHT_YELLOW;
      B_GRN:   light_b = LIGHT_GREEN;
      B_YEL:   light_b = LIGHT_YELLOW;
      WALK:    walk    = 1'b1;
      default: ;
    endcase
    cur_len_m1 = phase_len_m1(3'(state_q));
    p1 = (light_a != LIGHT_RED) && (light_b != LIGHT_RED);
    p2 = walk && ((light_a != LIGHT_RED) || (light_b != LIGHT_RED));
    p3 = illegal;
    p4 = time_left > cur_len_m1;
    p5 = (state_q == WALK);
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts each cycle's outputs.
module tb_intersection_scheduler;

  localparam int GA = 40;
  localparam int GB = 20;
  localparam int YT = 5;
  localparam int RT = 2;
  localparam int WT = 15;

  localparam logic [1:0] RED = 2'd0, GRN = 2'd1, YEL = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_b = 1'b0;
  logic       ped_req = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] light_a, light_b;
  logic       walk, ped_ack;
  logic [7:0] time_left;
  logic       p1, p2, p3, p4, p5;

  intersection_scheduler #(
    .GREEN_A (GA), .GREEN_B (GB), .YELLOW_T (YT), .ALLRED_T (RT), .WALK_T (WT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .car_b     (car_b),
    .ped_req   (ped_req),
    .hold      (hold),
    .light_a   (light_a),
    .light_b   (light_b),
    .walk      (walk),
    .ped_ack   (ped_ack),
    .time_left (time_left),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p5        (p5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit p5_seen  = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (phase name + cycles remaining) ----------------
  typedef enum int { M_MAIN_GO, M_MAIN_WARN, M_CLEAR1, M_SIDE_GO, M_SIDE_WARN, M_CLEAR2, M_PED } mphase_e;

  mphase_e m_phase;
  int      m_left;
  bit      m_car, m_ped, m_ack;

  function automatic int dur(input mphase_e p);
    case (p)
      M_MAIN_GO:                 return GA;
      M_MAIN_WARN, M_SIDE_WARN:  return YT;
      M_CLEAR1, M_CLEAR2:        return RT;
      M_SIDE_GO:                 return GB;
      default:                   return WT;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = M_MAIN_GO;
    m_left  = GA - 1;
    m_car   = 1'b0;
    m_ped   = 1'b0;
    m_ack   = 1'b0;
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input bit cb, input bit pr, input bit hd);
    bit      car_n, ped_n;
    mphase_e nxt;
    bit      go;
    car_n = m_car | cb;
    ped_n = m_ped | pr;
    if (!hd) begin
      m_ack = 1'b0;
      if (m_left > 0) begin
        m_left--;
      end else begin
        go  = 1'b1;
        nxt = m_phase;
        case (m_phase)
          M_MAIN_GO:   if (m_car || m_ped) nxt = M_MAIN_WARN; else go = 1'b0;
          M_MAIN_WARN: nxt = M_CLEAR1;
          M_CLEAR1:    nxt = m_ped ? M_PED : M_SIDE_GO;
          M_SIDE_GO:   nxt = M_SIDE_WARN;
          M_SIDE_WARN: nxt = M_CLEAR2;
          M_CLEAR2:    nxt = m_ped ? M_PED : M_MAIN_GO;
          default:     nxt = M_MAIN_GO;
        endcase
        if (go) begin
          m_phase = nxt;
          m_left  = dur(nxt) - 1;
          if (nxt == M_SIDE_GO) car_n = 1'b0;
          if (nxt == M_PED) begin
            ped_n = 1'b0;
            m_ack = 1'b1;
          end
        end
      end
    end
    m_car = car_n;
    m_ped = ped_n;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] la;
    logic [1:0] lb;
    logic       wk;
    logic       ack;
    logic [7:0] tl;
    logic       p5;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_expect();
    exp_t e;
    e.la  = (m_phase == M_MAIN_GO) ? GRN : (m_phase == M_MAIN_WARN) ? YEL : RED;
    e.lb  = (m_phase == M_SIDE_GO) ? GRN : (m_phase == M_SIDE_WARN) ? YEL : RED;
    e.wk  = (m_phase == M_PED);
    e.ack = m_ack;
    e.tl  = 8'(m_left);
    e.p5  = (m_phase == M_PED);
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("light_a",   8'(light_a), 8'(e.la));
        check("light_b",   8'(light_b), 8'(e.lb));
        check("walk",      8'(walk),    8'(e.wk));
        check("ped_ack",   8'(ped_ack), 8'(e.ack));
        check("time_left", time_left,   e.tl);
        check("p5",        8'(p5),      8'(e.p5));
        check("p1_p4",     8'({p1, p2, p3, p4}), 8'd0);
        if (p5) p5_seen = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset   = 1'b1;
    car_b   = 1'b0;
    ped_req = 1'b0;
    hold    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // kind: 0 idle, 1 car pulse, 2 ped pulse, 3 car + hold, 4 car held + mid reset, 5 random
  task automatic run_scenario(input int kind, input int ncycles);
    bit cb, pr, hd, rs;
    do_reset();
    for (int k = 0; k < ncycles; k++) begin
      push_expect();
      // Directed anchors from the timing description.
      if (kind == 0 && k == 0)  check("idle_tl_c0",   time_left, 8'd39);
      if (kind == 0 && k == 99) check("idle_tl_c99",  time_left, 8'd0);
      if (kind == 1 && k == 74) check("car_tl_c74",   time_left, 8'd39);
      if (kind == 2 && k == 47) check("ped_ack_c47",  8'(ped_ack), 8'd1);
      if (kind == 3 && k == 31) check("hold_tl_c31",  time_left, 8'd18);
      if (kind == 3 && k == 50) check("hold_ayel_c50", 8'(light_a), 8'(YEL));
      if (kind == 4 && k == 56) check("rst_tl_c56",   time_left, 8'd39);
      cb = 1'b0; pr = 1'b0; hd = 1'b0; rs = 1'b0;
      case (kind)
        1: cb = (k == 3);
        2: pr = (k == 10);
        3: begin cb = (k == 3); hd = (k >= 20 && k <= 29); end
        4: begin cb = 1'b1; rs = (k == 55); end
        5: begin
          cb = ($urandom_range(0, 19) == 0);
          pr = ($urandom_range(0, 39) == 0);
          hd = ($urandom_range(0, 15) == 0);
        end
        default: ;
      endcase
      car_b   = cb;
      ped_req = pr;
      hold    = hd;
      reset   = rs;
      if (rs) model_reset();
      else    model_step(cb, pr, hd);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    run_scenario(0, 100);
    run_scenario(1, 80);
    run_scenario(2, 70);
    run_scenario(3, 60);
    run_scenario(4, 70);
    run_scenario(5, 10000);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    check("p5_reached",    8'(p5_seen),      8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Sequencing controller for a two-road intersection: main road A and side road B. It drives both light heads and a pedestrian walk signal from one shared phase timer. It latches side-road car and pedestrian requests, and inserts yellow and all-red clearance phases. Safety properties are exported as `p*` outputs for the formal flow.

## Interface
- `GREEN_A`, default 40: minimum A-green duration in cycles.
- `GREEN_B`, default 20: B-green duration in cycles.
- `YELLOW_T`, default 5: yellow duration in cycles, used for both roads.
- `ALLRED_T`, default 2: all-red clearance duration in cycles.
- `WALK_T`, default 15: pedestrian walk duration in cycles.
- Every duration parameter is legal in the range 1..256.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `car_b` input 1: side-road car sensor, level.
- `ped_req` input 1: pedestrian button, level.
- `hold` input 1: freeze request (police/emergency).
- `light_a` output 2: A head, encoded RED=0, GREEN=1, YELLOW=2.
- `light_b` output 2: B head, same encoding.
- `walk` output 1: pedestrian walk lamp.
- `ped_ack` output 1: one-cycle pulse when a walk phase starts.
- `time_left` output 8: current phase-timer value.
- `p1` output 1: both heads non-RED at once.
- `p2` output 1: `walk` asserted while either head is non-RED.
- `p3` output 1: state register holds an unused encoding.
- `p4` output 1: `time_left` exceeds (duration of the current phase − 1).
- `p5` output 1: state is WALK; reachability target.

## Operation
- States and encodings: A_GRN=0, A_YEL=1, RED1=2, B_GRN=3, B_YEL=4, RED2=5, WALK=6. Encoding 7 is illegal.
- Light decode (combinational from the state register):
  - A_GRN: A=GREEN, B=RED.
  - A_YEL: A=YELLOW, B=RED.
  - B_GRN: A=RED, B=GREEN.
  - B_YEL: A=RED, B=YELLOW.
  - RED1, RED2, WALK: both heads RED.
  - `walk`=1 only in WALK.
- Timer behaviour:
  - On entry to a phase of duration T, the timer loads T−1.
  - It decrements by 1 each cycle while nonzero, so a phase lasts exactly T cycles.
  - In A_GRN the timer saturates at 0.
- Request latches:
  - `car_pend` is set on any cycle with `car_b`=1. It is cleared on the transition into B_GRN; the clear wins over a same-cycle set.
  - `ped_pend` is set on any cycle with `ped_req`=1. It is cleared on the transition into WALK; the clear wins over a same-cycle set.
- Transitions are taken only when the timer is 0:
  - A_GRN → A_YEL if `car_pend` or `ped_pend` is set; otherwise remain in A_GRN with the timer at 0.
  - A_YEL → RED1.
  - RED1 → WALK if `ped_pend`, else B_GRN.
  - B_GRN → B_YEL.
  - B_YEL → RED2.
  - RED2 → WALK if `ped_pend`, else A_GRN.
  - WALK → A_GRN always. Any pending car is served after the next A-green minimum; the main road has priority.
- `hold`=1:
  - State and timer do not update on that edge.
  - Request latches still update.
  - Outputs stay stable.
- `ped_ack` is registered. It is 1 on exactly the first cycle of WALK.
- An illegal state (7) recovers to A_GRN on the next edge, with the timer loaded to GREEN_A−1.

## Timing
- Reset values, on the cycle after `reset` is sampled high:
  - State A_GRN, `light_a`=GREEN, `light_b`=RED.
  - `walk`=0, `ped_ack`=0.
  - `time_left`=GREEN_A−1.
  - Both latches cleared.
  - `p1` through `p5` all 0.
- Reset dominates `hold` and any in-progress phase.
- Latency: a request sampled on cycle n is visible in its latch on cycle n+1. The earliest phase exit is the cycle after the timer reads 0.
- Every phase change from a non-RED head passes through YELLOW and then all-red. With this transition rule, `p1`, `p2`, `p3` and `p4` are never 1.

## Structure
- Shared package contents:
  - Light encoding constants (RED/GREEN/YELLOW).
  - State enum with encodings 0..6.
  - Default duration constants.
- Sub-module `phase_timer`:
  - 8-bit counter with load, load value, enable (`!hold`) and a `zero` flag.
  - The scheduler FSM, request latches, decode and properties stay in the top module.

## Test plan
Defaults are used throughout; cycle 0 is the first cycle after reset.
- No requests, 100 cycles → A=GREEN, B=RED throughout; `time_left` goes 39..0 by cycle 39 and stays 0.
- `car_b` pulse at cycle 3 → A_YEL 40–44, RED1 45–46, B_GRN 47–66, B_YEL 67–71, RED2 72–73, A_GRN at 74 with `time_left`=39.
- `ped_req` pulse at cycle 10 → RED1 45–46; WALK 47–61 with `walk`=1; `ped_ack`=1 at cycle 47 only; A_GRN at 62.
- `car_b` pulse at cycle 3 plus `hold` high cycles 20–29 → `time_left` is 19 on cycles 20–30 and 18 on cycle 31; A_YEL at cycle 50.
- `car_b` held high, then `reset` at cycle 55 (mid B_GRN) → at cycle 56: A_GRN, B=RED, `time_left`=39, latches cleared.
- Constrained-random `car_b`/`ped_req`/`hold` over 10k cycles → `p1`=`p2`=`p3`=`p4`=0 always; `p5` reached.
